fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter IP_BITS, default constants_pkg::INSTRUCTION_POINTER_BITS (8), instruction-pointer width.
REQ-002 SHALL have parameter MEM_DATA_BITS, default constants_pkg::MEMORY_DATA_BITS (8), memory byte width.
REQ-003 SHALL have parameter OFFSET_BITS, default constants_pkg::JUMP_OFFSET_BITS (8), signed jump-offset width.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port mem_addr, output, IP_BITS, program-memory read address.
REQ-007 SHALL have port mem_rd_en, output, 1, read strobe; data returns one cycle later.
REQ-008 SHALL have port mem_data, input, MEM_DATA_BITS, read data for the read issued in the previous cycle.
REQ-009 SHALL have port instr, output, 2*MEM_DATA_BITS, assembled instruction to the decoder.
REQ-010 SHALL have port instr_ip, output, IP_BITS, address of the instruction's first byte.
REQ-011 SHALL have port instr_valid, output, 1, instr and instr_ip are valid.
REQ-012 SHALL have port instr_ready, input, 1, decoder accepts instr this cycle.
REQ-013 SHALL have port jump_en, input, 1, redirect request, qualified by the handshake.
REQ-014 SHALL have port jump_offset, input, OFFSET_BITS, two's-complement relative offset.

Function
REQ-015 SHALL implement FSM states START, FETCH_HI, FETCH_LO, CAPTURE, HOLD.
REQ-016 START: no read issued; next state FETCH_HI.
REQ-017 FETCH_HI: mem_rd_en=1, mem_addr=ip; next state FETCH_LO.
REQ-018 FETCH_LO: capture mem_data into instr[15:8]; mem_rd_en=1, mem_addr=ip+1 mod 2^IP_BITS; next state CAPTURE.
REQ-019 CAPTURE: capture mem_data into instr[7:0]; mem_rd_en=0; next state HOLD.
REQ-020 HOLD: instr_valid=1, instr_ip=ip; instr, instr_ip stay stable until the handshake.
REQ-021 Handshake SHALL complete in a cycle where instr_valid=1 and instr_ready=1; next state FETCH_HI.
REQ-022 At handshake with jump_en=0: ip <= ip+2 mod 2^IP_BITS.
REQ-023 At handshake with jump_en=1: ip <= ip+2+sign_extend(jump_offset), mod 2^IP_BITS.
REQ-024 jump_en and jump_offset SHALL be ignored outside a handshake cycle.
REQ-025 mem_rd_en and mem_addr SHALL be decoded from state; mem_addr=0 whenever mem_rd_en=0.
REQ-026 instr_valid SHALL be 0 in every state except HOLD.
REQ-027 Latency from entering FETCH_HI to instr_valid=1 SHALL be 3 cycles; throughput is one instruction per 4 cycles when instr_ready is held at 1.
REQ-028 Address wrap: ip=0xFF fetches bytes 0xFF then 0x00; the sequential next ip is 0x01.
REQ-029 instr_ready=1 while instr_valid=0 SHALL have no effect.

Reset
REQ-030 While rst_n=0, SHALL force state=START, ip=0, instr=0, mem_rd_en=0, mem_addr=0, instr_valid=0, instr_ip=0, asynchronously.
REQ-031 Reset asserted mid-fetch or in HOLD SHALL discard the partial or held instruction; no handshake is reported.
REQ-032 After rst_n deasserts, the first read SHALL be issued at address 0 on the second rising edge.

Structure
REQ-033 constants_pkg SHALL gain the enum FetchState {START, FETCH_HI, FETCH_LO, CAPTURE, HOLD} and the constant INSTRUCTION_BITS = 2*MEMORY_DATA_BITS.
REQ-034 SHALL be a single module with no sub-module; the adder and FSM are inline.

Verification
REQ-035 Reset then memory[0]=0x12, memory[1]=0x34, instr_ready=1 -> instr=0x1234, instr_ip=0x00, instr_valid for one cycle; next fetch at 0x02.
REQ-036 instr_ready=0 for 5 cycles in HOLD -> instr and instr_ip stable, mem_rd_en=0; handshake on cycle 6, then FETCH_HI at the same ip+2.
REQ-037 Handshake at instr_ip=0x10 with jump_en=1, jump_offset=0xFC (-4) -> next fetch at 0x0E; jump_offset=0x06 -> next fetch at 0x18.
REQ-038 ip=0xFF -> reads 0xFF then 0x00; instr_ip=0xFF; sequential next fetch at 0x01; a jump from 0xFE with offset 0x05 -> next fetch at 0x05.
REQ-039 jump_en=1 pulsed during FETCH_LO -> ignored; next fetch is sequential.
REQ-040 rst_n pulled low during FETCH_LO at ip=0x20 -> all outputs 0 immediately; after release, fetch restarts at 0x00.

Source files
------------

// File: rtl/constants_pkg.sv
// Shared widths and the fetch sequencer state encoding.
package constants_pkg;

   localparam int INSTRUCTION_POINTER_BITS = 8;
   localparam int MEMORY_DATA_BITS         = 8;
   localparam int JUMP_OFFSET_BITS         = 8;
   localparam int INSTRUCTION_BITS         = 2 * MEMORY_DATA_BITS;

   // One read per memory byte, one cycle to land the low byte, then park
   // the assembled instruction until the decoder takes it.
   typedef enum logic [2:0] {
      START    = 3'd0,
      FETCH_HI = 3'd1,
      FETCH_LO = 3'd2,
      CAPTURE  = 3'd3,
      HOLD     = 3'd4
   } FetchState;

endpackage

// File: rtl/fetch_unit.sv
// Two-byte instruction fetch: reads the high byte then the low byte from a
// one-cycle-latency program memory, presents the instruction with a
// valid/ready handshake, and advances or redirects the instruction pointer
// when the decoder accepts it.
module fetch_unit
   import constants_pkg::*;
#(
   parameter int IP_BITS       = constants_pkg::INSTRUCTION_POINTER_BITS,
   parameter int MEM_DATA_BITS = constants_pkg::MEMORY_DATA_BITS,
   parameter int OFFSET_BITS   = constants_pkg::JUMP_OFFSET_BITS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic [IP_BITS-1:0]         mem_addr,
   output logic                       mem_rd_en,
   input  logic [MEM_DATA_BITS-1:0]   mem_data,
   output logic [2*MEM_DATA_BITS-1:0] instr,
   output logic [IP_BITS-1:0]         instr_ip,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   input  logic                       jump_en,
   input  logic [OFFSET_BITS-1:0]     jump_offset
);

   // Adder is sized to the wider of ip and offset so the sign extension of
   // the offset is never lost before the final wrap to IP_BITS.
   localparam int SUM_BITS = (IP_BITS > OFFSET_BITS) ? IP_BITS : OFFSET_BITS;

   FetchState                  state_q, state_d;
   logic [IP_BITS-1:0]         ip_q, ip_d;
   logic [2*MEM_DATA_BITS-1:0] instr_q;
   logic                       hs;
   logic [SUM_BITS-1:0]        off_ext;
   logic [SUM_BITS-1:0]        ip_sum;
   logic [IP_BITS-1:0]         ip_next;

   // Handshake only exists while the instruction is being presented.
   assign hs = (state_q == HOLD) && instr_ready;

   // Next ip: ip + 2, plus the sign-extended offset when redirecting.
   always_comb begin
      off_ext = jump_en ? SUM_BITS'(signed'(jump_offset)) : '0;
      ip_sum  = SUM_BITS'(ip_q) + SUM_BITS'(2) + off_ext;
      ip_next = ip_sum[IP_BITS-1:0];
   end

   // Sequencer next-state and state-decoded memory/decoder outputs.
   always_comb begin
      state_d     = state_q;
      ip_d        = ip_q;
      mem_rd_en   = 1'b0;
      mem_addr    = '0;
      instr_valid = 1'b0;
      case (state_q)
         START: begin
            state_d = FETCH_HI;
         end
         FETCH_HI: begin
            mem_rd_en = 1'b1;
            mem_addr  = ip_q;
            state_d   = FETCH_LO;
         end
         FETCH_LO: begin
            mem_rd_en = 1'b1;
            mem_addr  = ip_q + IP_BITS'(1);
            state_d   = CAPTURE;
         end
         CAPTURE: begin
            state_d = HOLD;
         end
         HOLD: begin
            instr_valid = 1'b1;
            if (hs) begin
               ip_d    = ip_next;
               state_d = FETCH_HI;
            end
         end
         default: begin
            state_d = START;
         end
      endcase
   end

   // State and instruction pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= START;
         ip_q    <= '0;
      end else begin
         state_q <= state_d;
         ip_q    <= ip_d;
      end
   end

   // Assemble the instruction: high byte lands during FETCH_LO, low byte
   // during CAPTURE; held untouched through HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
      end else if (state_q == FETCH_LO) begin
         instr_q[2*MEM_DATA_BITS-1:MEM_DATA_BITS] <= mem_data;
      end else if (state_q == CAPTURE) begin
         instr_q[MEM_DATA_BITS-1:0] <= mem_data;
      end
   end

   assign instr    = instr_q;
   assign instr_ip = ip_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory model and
// a scoreboard of expected {instr, instr_ip} pairs.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic [7:0]  mem_addr;
   logic        mem_rd_en;
   logic [7:0]  mem_data;
   logic [15:0] instr;
   logic [7:0]  instr_ip;
   logic        instr_valid;
   logic        instr_ready;
   logic        jump_en;
   logic [7:0]  jump_offset;

   logic [7:0]  mem [256];
   logic [23:0] sb [$];
   logic [15:0] last_instr;
   logic [7:0]  last_ip;
   int          checks;
   int          errors;

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_addr    (mem_addr),
      .mem_rd_en   (mem_rd_en),
      .mem_data    (mem_data),
      .instr       (instr),
      .instr_ip    (instr_ip),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .jump_en     (jump_en),
      .jump_offset (jump_offset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Program memory: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_data <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
      chk({tag, "_addr"},  32'(mem_addr), 0);
      chk({tag, "_instr"}, 32'(instr), 0);
      chk({tag, "_valid"}, 32'(instr_valid), 0);
      chk({tag, "_ip"},    32'(instr_ip), 0);
   endtask

   // Entered at the negedge of a FETCH_HI cycle; leaves at the first HOLD
   // negedge after checking the presented instruction against the scoreboard.
   task automatic fetch_cycle(input logic [7:0] addr, input bit glitch, input string tag);
      logic [7:0]  a1;
      logic [23:0] exp;
      a1 = addr + 8'd1;
      chk({tag, "_hi_rd"},   32'(mem_rd_en), 1);
      chk({tag, "_hi_addr"}, 32'(mem_addr), 32'(addr));
      chk({tag, "_hi_vld"},  32'(instr_valid), 0);
      sb.push_back({mem[addr], mem[a1], addr});
      step();
      chk({tag, "_lo_rd"},   32'(mem_rd_en), 1);
      chk({tag, "_lo_addr"}, 32'(mem_addr), 32'(a1));
      chk({tag, "_lo_vld"},  32'(instr_valid), 0);
      if (glitch) begin
         jump_en     = 1'b1;
         jump_offset = 8'h40;
         instr_ready = 1'b1;
      end
      step();
      jump_en     = 1'b0;
      instr_ready = 1'b0;
      chk({tag, "_cap_rd"},   32'(mem_rd_en), 0);
      chk({tag, "_cap_addr"}, 32'(mem_addr), 0);
      chk({tag, "_cap_vld"},  32'(instr_valid), 0);
      step();
      chk({tag, "_hold_vld"}, 32'(instr_valid), 1);
      chk({tag, "_hold_rd"},  32'(mem_rd_en), 0);
      chk({tag, "_sb_avail"}, 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         exp = sb.pop_front();
         chk({tag, "_instr"}, 32'(instr), 32'(exp[23:8]));
         chk({tag, "_ip"},    32'(instr_ip), 32'(exp[7:0]));
         last_instr = exp[23:8];
         last_ip    = exp[7:0];
      end
   endtask

   // Stall in HOLD for 'hold' cycles, then complete the handshake.
   task automatic handshake(input int hold, input bit jen, input logic [7:0] off,
                            input string tag);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({tag, "_stall_vld"},   32'(instr_valid), 1);
         chk({tag, "_stall_instr"}, 32'(instr), 32'(last_instr));
         chk({tag, "_stall_ip"},    32'(instr_ip), 32'(last_ip));
         chk({tag, "_stall_rd"},    32'(mem_rd_en), 0);
      end
      instr_ready = 1'b1;
      jump_en     = jen;
      jump_offset = off;
      step();
      instr_ready = 1'b0;
      jump_en     = 1'b0;
      jump_offset = 8'h00;
      chk({tag, "_post_vld"}, 32'(instr_valid), 0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      instr_ready = 1'b0;
      jump_en     = 1'b0;
      jump_offset = 8'h00;
      last_instr  = '0;
      last_ip     = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h12;
      mem[1] = 8'h34;

      // Reset state, held across several edges.
      step();
      step();
      chk_zero("rst");

      // Release between edges: still START, no read yet.
      rst_n = 1'b1;
      #1;
      chk("start_rd", 32'(mem_rd_en), 0);
      step();

      // First instruction at 0x00, sequential to 0x02.
      fetch_cycle(8'h00, 1'b0, "i0");
      chk("i0_value", 32'(instr), 32'h1234);
      handshake(0, 1'b0, 8'h00, "hs0");

      // Decoder stalls 5 cycles; accept on the 6th.
      fetch_cycle(8'h02, 1'b0, "i2");
      handshake(5, 1'b0, 8'h00, "hs2");

      // Steer to 0x10, then exercise backward and forward jumps.
      fetch_cycle(8'h04, 1'b0, "i4");
      handshake(0, 1'b1, 8'h0A, "hs4");
      fetch_cycle(8'h10, 1'b0, "i10a");
      handshake(0, 1'b1, 8'hFC, "jback");
      fetch_cycle(8'h0E, 1'b0, "i0e");
      handshake(0, 1'b1, 8'h00, "hs0e");
      fetch_cycle(8'h10, 1'b0, "i10b");
      handshake(0, 1'b1, 8'h06, "jfwd");
      fetch_cycle(8'h18, 1'b0, "i18");

      // Wrap: 0xFF fetches 0xFF/0x00, then sequential to 0x01.
      handshake(0, 1'b1, 8'hE5, "hs18");
      fetch_cycle(8'hFF, 1'b0, "iff");
      handshake(0, 1'b0, 8'h00, "hsff");
      fetch_cycle(8'h01, 1'b0, "i01");
      handshake(0, 1'b1, 8'hFB, "hs01");
      fetch_cycle(8'hFE, 1'b0, "ife");
      handshake(0, 1'b1, 8'h05, "jwrap");

      // Jump/ready pulsed mid-fetch must be ignored.
      fetch_cycle(8'h05, 1'b1, "i05");
      handshake(0, 1'b0, 8'h00, "hs05");
      fetch_cycle(8'h07, 1'b0, "i07");
      handshake(0, 1'b1, 8'h17, "hs07");

      // Reset during FETCH_LO at 0x20 clears everything immediately.
      chk("r20_hi_addr", 32'(mem_addr), 32'h20);
      step();
      chk("r20_lo_addr", 32'(mem_addr), 32'h21);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      fetch_cycle(8'h00, 1'b0, "rst_i0");
      handshake(0, 1'b0, 8'h00, "rst_hs0");
      chk("rst_next_addr", 32'(mem_addr), 32'h02);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
